// File: rtl/control_pkg.sv
// Shared RV32I type packages for the MP0 control unit and datapath.
// rv32i_types: opcode/ALU/branch/funct3 encodings.
// rv32i_mux_types: named datapath mux select values.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    add  = 3'b000,
    sll  = 3'b001,
    slt  = 3'b010,
    sltu = 3'b011,
    axor = 3'b100,
    sr   = 3'b101,
    aor  = 3'b110,
    aand = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

endpackage

package rv32i_mux_types;

  typedef enum logic { pcmux_pc_plus4 = 1'b0, pcmux_alu_out = 1'b1 } pcmux_sel_t;
  typedef enum logic { marmux_pc_out = 1'b0, marmux_alu_out = 1'b1 } marmux_sel_t;
  typedef enum logic { cmpmux_rs2_out = 1'b0, cmpmux_i_imm = 1'b1 } cmpmux_sel_t;
  typedef enum logic { alumux1_rs1_out = 1'b0, alumux1_pc_out = 1'b1 } alumux1_sel_t;

  typedef enum logic [1:0] {
    alumux2_i_imm = 2'd0,
    alumux2_u_imm = 2'd1,
    alumux2_b_imm = 2'd2,
    alumux2_s_imm = 2'd3
  } alumux2_sel_t;

  typedef enum logic [1:0] {
    regfilemux_alu_out = 2'd0,
    regfilemux_br_en   = 2'd1,
    regfilemux_u_imm   = 2'd2,
    regfilemux_mdr     = 2'd3
  } regfilemux_sel_t;

endpackage

// File: rtl/control.sv
// Multicycle Moore control unit for the RV32I MP0 core.
// Optional feature: CONTROL_ILLEGAL_HALT_EN -- illegal instructions park the
// machine in HALT with a sticky illegal flag; otherwise they retire as NOPs.
module control
  import rv32i_types::*;
  import rv32i_mux_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  rv32i_opcode     opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            br_en,
  input  logic            mem_resp,
  output logic            load_pc,
  output logic            load_ir,
  output logic            load_regfile,
  output logic            load_mar,
  output logic            load_mdr,
  output logic            load_mem_data_out,
  output logic            pcmux_sel,
  output logic            marmux_sel,
  output logic            cmpmux_sel,
  output logic            alumux1_sel,
  output logic [1:0]      alumux2_sel,
  output logic [1:0]      regfilemux_sel,
  output alu_ops          aluop,
  output branch_funct3_t  cmpop,
  output logic            mem_read,
  output logic            mem_write,
  output logic [3:0]      mem_byte_enable,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_IMM, S_LUI, S_AUIPC, S_BR,
    S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2,
`ifdef CONTROL_ILLEGAL_HALT_EN
    S_HALT
`else
    S_NOP
`endif
  } state_t;

`ifdef CONTROL_ILLEGAL_HALT_EN
  localparam state_t S_ILL = S_HALT;
`else
  localparam state_t S_ILL = S_NOP;
`endif

  state_t state_q, state_d;

  // Only funct7[5] matters (srai vs srli); the rest is deliberately ignored.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // State register; reset restarts at instruction fetch.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH1;
    else     state_q <= state_d;
  end

  // Next-state sequencing; memory states hold until mem_resp.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: if (mem_resp) state_d = S_FETCH3;
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          op_imm:   state_d = S_IMM;
          op_lui:   state_d = S_LUI;
          op_auipc: state_d = S_AUIPC;
          op_br:    state_d = S_BR;
          op_load:  state_d = (funct3 == lw) ? S_CALC_ADDR : S_ILL;
          op_store: state_d = (funct3 == sw) ? S_CALC_ADDR : S_ILL;
          default:  state_d = S_ILL;
        endcase
      end
      S_CALC_ADDR: state_d = (opcode == op_store) ? S_ST1 : S_LD1;
      S_LD1:    if (mem_resp) state_d = S_LD2;
      S_ST1:    if (mem_resp) state_d = S_ST2;
`ifdef CONTROL_ILLEGAL_HALT_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_FETCH1;
    endcase
  end

  task automatic set_defaults();
    load_pc           = 1'b0;
    load_ir           = 1'b0;
    load_regfile      = 1'b0;
    load_mar          = 1'b0;
    load_mdr          = 1'b0;
    load_mem_data_out = 1'b0;
    pcmux_sel         = pcmux_pc_plus4;
    marmux_sel        = marmux_pc_out;
    cmpmux_sel        = cmpmux_rs2_out;
    alumux1_sel       = alumux1_rs1_out;
    alumux2_sel       = alumux2_i_imm;
    regfilemux_sel    = regfilemux_alu_out;
    aluop             = alu_add;
    cmpop             = branch_funct3_t'(funct3);
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_byte_enable   = 4'b1111;
    illegal           = 1'b0;
  endtask

  // Moore outputs; reset forces everything (including the constant byte
  // enable and the funct3 passthrough) to zero so an access aborts at once.
  always_comb begin
    set_defaults();
    if (rst) begin
      cmpop           = beq;
      mem_byte_enable = 4'b0000;
    end else begin
      case (state_q)
        S_FETCH1: load_mar = 1'b1;
        S_FETCH2: begin mem_read = 1'b1; load_mdr = 1'b1; end
        S_FETCH3: load_ir = 1'b1;
        S_IMM: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          aluop        = alu_ops'(funct3);
          case (funct3)
            slt: begin
              cmpmux_sel = cmpmux_i_imm; cmpop = blt;
              regfilemux_sel = regfilemux_br_en;
            end
            sltu: begin
              cmpmux_sel = cmpmux_i_imm; cmpop = bltu;
              regfilemux_sel = regfilemux_br_en;
            end
            sr: aluop = funct7[5] ? alu_sra : alu_srl;
            default: ;
          endcase
        end
        S_LUI: begin
          regfilemux_sel = regfilemux_u_imm;
          load_regfile = 1'b1; load_pc = 1'b1;
        end
        S_AUIPC: begin
          alumux1_sel = alumux1_pc_out; alumux2_sel = alumux2_u_imm;
          load_regfile = 1'b1; load_pc = 1'b1;
        end
        S_BR: begin
          alumux1_sel = alumux1_pc_out; alumux2_sel = alumux2_b_imm;
          pcmux_sel = br_en; load_pc = 1'b1;
        end
        S_CALC_ADDR: begin
          marmux_sel = marmux_alu_out; load_mar = 1'b1;
          if (opcode == op_store) begin
            alumux2_sel = alumux2_s_imm; load_mem_data_out = 1'b1;
          end
        end
        S_LD1: begin mem_read = 1'b1; load_mdr = 1'b1; end
        S_LD2: begin
          regfilemux_sel = regfilemux_mdr;
          load_regfile = 1'b1; load_pc = 1'b1;
        end
        S_ST1: mem_write = 1'b1;
        S_ST2: load_pc = 1'b1;
`ifdef CONTROL_ILLEGAL_HALT_EN
        S_HALT: illegal = 1'b1;
`else
        S_NOP: load_pc = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// Randomized self-checking bench for control: each instruction is run from
// FETCH1 to its PC update and compared with a per-instruction expectation.
module tb_control;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst, br_en, mem_resp;
  rv32i_opcode opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_mem_data_out;
  logic pcmux_sel, marmux_sel, cmpmux_sel, alumux1_sel;
  logic [1:0] alumux2_sel, regfilemux_sel;
  alu_ops aluop;
  branch_funct3_t cmpop;
  logic mem_read, mem_write, illegal;
  logic [3:0] mem_byte_enable;
  logic [26:0] outs;

  control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_mem_data_out(load_mem_data_out),
    .pcmux_sel(pcmux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
    .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .aluop(aluop), .cmpop(cmpop),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .illegal(illegal)
  );

  assign outs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_mem_data_out,
                 pcmux_sel, marmux_sel, cmpmux_sel, alumux1_sel, alumux2_sel,
                 regfilemux_sel, aluop, cmpop, mem_read, mem_write,
                 mem_byte_enable, illegal};

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Expected architectural behaviour of one instruction.
  typedef struct {
    int lat; int rd; int wr; bit st;
    logic rf; logic [1:0] rfm; logic pcm; logic a1; logic [1:0] a2; logic cm;
    logic [2:0] alu; logic [2:0] cmp;
  } exp_t;

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic br,
                                 input int fd, input int md);
    exp_t e;
    e.lat = 5 + fd; e.rd = fd + 1; e.wr = 0; e.st = 0;
    e.rf = 0; e.rfm = 0; e.pcm = 0; e.a1 = 0; e.a2 = 0; e.cm = 0;
    e.alu = 3'd0; e.cmp = f3;
    if (op == 7'h13) begin                      // register-immediate ALU
      e.rf = 1;
      e.alu = (f3 == 3'd5 && f7[5]) ? 3'd2 : f3;  // arithmetic right shift
      if (f3 == 3'd2) begin e.cm = 1; e.cmp = 3'd4; e.rfm = 1; end
      if (f3 == 3'd3) begin e.cm = 1; e.cmp = 3'd6; e.rfm = 1; end
    end else if (op == 7'h37) begin             // lui
      e.rf = 1; e.rfm = 2;
    end else if (op == 7'h17) begin             // auipc
      e.rf = 1; e.a1 = 1; e.a2 = 1;
    end else if (op == 7'h63) begin             // branch
      e.a1 = 1; e.a2 = 2; e.pcm = br;
    end else if (op == 7'h03 && f3 == 3'd2) begin  // lw
      e.lat += 2 + md; e.rd += md + 1; e.rf = 1; e.rfm = 3;
    end else if (op == 7'h23 && f3 == 3'd2) begin  // sw
      e.lat += 2 + md; e.wr = md + 1; e.st = 1;
    end
    return e;                                   // anything else: plain pc+4
  endfunction

  // Memory model: answers the n-th access after its programmed wait count,
  // and throws stray responses while idle.
  task automatic respond(input int fd, input int md, inout int acc, inout int waitc);
    if (mem_read || mem_write) begin
      if (waitc == ((acc == 0) ? fd : md)) begin
        mem_resp = 1'b1; waitc = 0; acc++;
      end else begin
        mem_resp = 1'b0; waitc++;
      end
    end else begin
      mem_resp = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Starts just after an edge with the DUT in FETCH1.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic br,
                           input int fd, input int md);
    exp_t e;
    int cyc = 0, rd = 0, wr = 0, ir = 0, acc = 0, waitc = 0;
    bit done = 0;
    logic s_rf = 0, s_pcm = 0, s_a1 = 0, s_cm = 0, s_ill = 0, s_mar = 0;
    logic [1:0] s_a2 = 0, s_rfm = 0;
    logic [2:0] s_alu = 0, s_cmp = 0;
    logic [3:0] s_mbe = 0;
    e = model(op, f3, f7, br, fd, md);
    opcode = rv32i_opcode'(op); funct3 = f3; funct7 = f7; br_en = br;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      rd += int'(mem_read); wr += int'(mem_write); ir += int'(load_ir);
      if (load_mar && marmux_sel) begin
        chk("addr_alumux2", alumux2_sel, e.st ? 2'd3 : 2'd0);
        chk("addr_mdo", load_mem_data_out, e.st);
      end
      respond(fd, md, acc, waitc);
      if (load_pc) begin
        done = 1;
        s_rf = load_regfile; s_pcm = pcmux_sel; s_a1 = alumux1_sel; s_cm = cmpmux_sel;
        s_a2 = alumux2_sel; s_rfm = regfilemux_sel; s_alu = aluop; s_cmp = cmpop;
        s_mbe = mem_byte_enable; s_ill = illegal; s_mar = load_mar;
      end
      @(posedge clk); #1;
      mem_resp = 1'b0;
    end
    chk("timeout", done, 1'b1);
    chk("latency", cyc, e.lat);
    chk("read_cycles", rd, e.rd);
    chk("write_cycles", wr, e.wr);
    chk("load_ir_cnt", ir, 1);
    chk("regfile", s_rf, e.rf);
    chk("regfilemux", s_rfm, e.rfm);
    chk("pcmux", s_pcm, e.pcm);
    chk("alumux1", s_a1, e.a1);
    chk("alumux2", s_a2, e.a2);
    chk("cmpmux", s_cm, e.cm);
    chk("aluop", s_alu, e.alu);
    chk("cmpop", s_cmp, e.cmp);
    chk("byte_en", s_mbe, 4'hf);
    chk("illegal", s_ill, 1'b0);
    chk("commit_mar", s_mar, 1'b0);
  endtask

  task automatic rand_instr(input bit allow_ill);
    int k;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] brf [6];
    brf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    k  = $urandom_range(0, allow_ill ? 6 : 5);
    f3 = 3'($urandom);
    f7 = 7'($urandom);
    case (k)
      0: begin op = 7'h13; if (f3 == 3'd5) f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
      1: op = 7'h37;
      2: op = 7'h17;
      3: begin op = 7'h63; f3 = brf[$urandom_range(0, 5)]; end
      4: begin op = 7'h03; f3 = 3'd2; end
      5: begin op = 7'h23; f3 = 3'd2; end
      default: begin
        case ($urandom_range(0, 3))
          0: op = 7'h7f;
          1: op = 7'h33;
          2: begin op = 7'h03; if (f3 == 3'd2) f3 = 3'd0; end
          default: begin op = 7'h23; if (f3 == 3'd2) f3 = 3'd1; end
        endcase
      end
    endcase
    run_instr(op, f3, f7, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1; mem_resp = 1'b0; br_en = 1'b0;
    opcode = op_imm; funct3 = 3'd0; funct7 = 7'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs, 27'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed instructions.
    run_instr(7'h13, 3'd0, 7'h00, 1'b0, 0, 0);   // addi
    run_instr(7'h13, 3'd5, 7'h20, 1'b0, 0, 0);   // srai
    run_instr(7'h13, 3'd5, 7'h00, 1'b0, 1, 0);   // srli
    run_instr(7'h13, 3'd3, 7'h00, 1'b0, 0, 0);   // sltiu
    run_instr(7'h63, 3'd0, 7'h00, 1'b1, 0, 0);   // beq taken
    run_instr(7'h63, 3'd0, 7'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(7'h03, 3'd2, 7'h00, 1'b0, 0, 3);   // lw, 3 wait cycles
    run_instr(7'h23, 3'd2, 7'h00, 1'b0, 0, 2);   // sw
    run_instr(7'h37, 3'd0, 7'h00, 1'b0, 2, 0);   // lui
    run_instr(7'h17, 3'd0, 7'h00, 1'b0, 0, 0);   // auipc

    // Reset in the middle of an instruction fetch.
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_read", mem_read, 1'b0);
    chk("rst_mid_outs", outs, 27'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(7'h13, 3'd4, 7'h00, 1'b0, 0, 0);

`ifdef CONTROL_ILLEGAL_HALT_EN
    for (int n = 0; n < 80; n++) rand_instr(1'b0);
    begin
      int rd = 0, pcs = 0, acc = 0, waitc = 0, fd;
      fd = $urandom_range(0, 2);
      opcode = rv32i_opcode'(7'h7f);
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        rd += int'(mem_read); pcs += int'(load_pc);
        respond(fd, 0, acc, waitc);
        @(posedge clk); #1;
        mem_resp = 1'b0;
      end
      @(negedge clk);
      chk("halt_reads", rd, fd + 1);
      chk("halt_no_pc", pcs, 0);
      chk("halt_illegal", illegal, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("halt_rst_clear", illegal, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(7'h13, 3'd0, 7'h00, 1'b0, 0, 0);
    end
`else
    run_instr(7'h7f, 3'd0, 7'h00, 1'b0, 0, 0);   // illegal -> nop
    run_instr(7'h03, 3'd1, 7'h00, 1'b0, 1, 0);   // lh is illegal
    for (int n = 0; n < 80; n++) rand_instr(1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
